// File: rtl/sd_resp_rx_if.sv
// Command-line response receiver bus: arm/config inputs, serial CMD line,
// and the decoded response/status returned to the host controller FSM.
interface sd_resp_rx_if;
    logic         start;
    logic         resp_long;
    logic         crc_check;
    logic         sd_cmd;
    logic         busy;
    logic         done;
    logic         timeout;
    logic         crc_err;
    logic         frame_err;
    logic [5:0]   resp_index;
    logic [31:0]  resp_arg;
    logic [119:0] resp_r2;

    // Host side: arms the receiver and drives the resolved CMD line.
    modport master (
        output start, resp_long, crc_check, sd_cmd,
        input  busy, done, timeout, crc_err, frame_err,
               resp_index, resp_arg, resp_r2
    );

    // Receiver side.
    modport slave (
        input  start, resp_long, crc_check, sd_cmd,
        output busy, done, timeout, crc_err, frame_err,
               resp_index, resp_arg, resp_r2
    );
endinterface

// File: rtl/sd_resp_rx.sv
// SD command-line response receiver. Armed by start, waits up to NCR for the
// card start bit, deserialises a 48-bit or 136-bit token, checks CRC7 and
// framing, and reports results with a one-cycle done pulse.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | not armed; start latches format and clears status
//   WAIT_START | counting idle-high samples until start bit or timeout
//   RECV       | shifting token bits after the start bit, MSB first
//   DONE       | one cycle: publish results, pulse done
module sd_resp_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        sd_clk,
    input  logic        reset,
    sd_resp_rx_if.slave bus
);

    localparam int unsigned WCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECV       = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t              state_q;
    logic                long_q;
    logic                chk_q;
    logic                tmo_hit_q;
    logic [WCNT_W-1:0]   wait_cnt_q;
    logic [7:0]          bit_cnt_q;
    // Token bits below the start bit; the start bit itself is always 0 and
    // is not stored. Short tokens occupy [46:0], long tokens [134:0].
    logic [134:0]        shift_q;
    logic [6:0]          crc_q;
    logic [6:0]          crc_d;
    logic                crc_fb;
    logic                crc_en;

    logic                busy_q;
    logic                done_q;
    logic                timeout_q;
    logic                crc_err_q;
    logic                frame_err_q;
    logic [5:0]          index_q;
    logic [31:0]         arg_q;
    logic [119:0]        r2_q;

    // Serial CRC7 step and coverage window: the incoming bit's token index is
    // bit_cnt_q-1, covered for indices 8..47 (short) or 8..127 (long).
    always_comb begin
        crc_fb = crc_q[6] ^ bus.sd_cmd;
        crc_d  = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
        crc_en = (bit_cnt_q >= 8'd9) && (bit_cnt_q <= (long_q ? 8'd128 : 8'd48));
    end

    // Receiver FSM with registered status and data outputs.
    always_ff @(posedge sd_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            long_q      <= 1'b0;
            chk_q       <= 1'b0;
            tmo_hit_q   <= 1'b0;
            wait_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            crc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            index_q     <= '0;
            arg_q       <= '0;
            r2_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        long_q      <= bus.resp_long;
                        chk_q       <= bus.crc_check;
                        tmo_hit_q   <= 1'b0;
                        wait_cnt_q  <= '0;
                        shift_q     <= '0;
                        crc_q       <= '0;
                        timeout_q   <= 1'b0;
                        crc_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                        index_q     <= '0;
                        arg_q       <= '0;
                        r2_q        <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    // The start bit is 0, so it leaves a zero-initialised CRC
                    // unchanged; it needs no CRC step of its own.
                    if (!bus.sd_cmd) begin
                        bit_cnt_q <= long_q ? 8'd135 : 8'd47;
                        state_q   <= RECV;
                    end else if (wait_cnt_q == WCNT_LAST) begin
                        tmo_hit_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                RECV: begin
                    shift_q   <= {shift_q[133:0], bus.sd_cmd};
                    bit_cnt_q <= bit_cnt_q - 1'b1;
                    if (crc_en) begin
                        crc_q <= crc_d;
                    end
                    if (bit_cnt_q == 8'd1) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (tmo_hit_q) begin
                        timeout_q <= 1'b1;
                    end else begin
                        crc_err_q <= chk_q & (crc_q != shift_q[7:1]);
                        if (long_q) begin
                            frame_err_q <= shift_q[134] | ~shift_q[0];
                            index_q     <= shift_q[133:128];
                            r2_q        <= shift_q[127:8];
                        end else begin
                            frame_err_q <= shift_q[46] | ~shift_q[0];
                            index_q     <= shift_q[45:40];
                            arg_q       <= shift_q[39:8];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.resp_index = index_q;
    assign bus.resp_arg   = arg_q;
    assign bus.resp_r2    = r2_q;

endmodule
